// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Purpose: shared types and helpers for the pipeline hazard controller.
// Contents: FSM state encoding, register-index width, load-use hazard check.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Load in EX feeds a source actually read by the ID instruction; $0 never hazards.
  function automatic logic lu_hazard(
    input logic             memread,
    input logic [REG_W-1:0] dest,
    input logic             uses_rs,
    input logic [REG_W-1:0] rs,
    input logic             uses_rt,
    input logic [REG_W-1:0] rt
  );
    return memread && (dest != REG_ZERO) &&
           ((uses_rs && (rs == dest)) || (uses_rt && (rt == dest)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Purpose: saturating up-counter used for pipeline performance statistics.
// Ports: clk, rst_n (async active-low), en (count), clr (sync clear), count (W bits).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: sequences the 5-stage pipeline: load-use bubbles, branch/jump redirects,
//   data-memory wait freezes, sticky dmem timeout flag and stall/flush statistics.
// Inputs : CLK, Reset_L (async active-low), id_rs/id_rt, id_uses_rs/id_uses_rt, id_jump,
//          ex_memread, ex_dest, ex_branch_taken, dmem_req, dmem_ready.
// Outputs: PCWrite, IFIDWrite, if_flush, bubble, pipe_en (combinational from state+inputs),
//          mem_err (registered, sticky), stall_cnt, flush_cnt (registered, saturating).
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned LU_STALL_CYC = 1,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             if_flush,
  output logic             bubble,
  output logic             pipe_en,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned REM_W  = (LU_STALL_CYC > 1) ? $clog2(LU_STALL_CYC) : 1;
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e             state, state_nxt;
  state_e             saved_state, saved_nxt;
  state_e             eff_state;
  logic [REM_W-1:0]   remaining, rem_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               lu_hit;
  logic               mem_wait;
  logic               stall_inc;
  logic               flush_inc;

  assign lu_hit   = lu_hazard(ex_memread, ex_dest, id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign mem_wait = dmem_req & ~dmem_ready;

  // While waiting, behave as the frozen pre-wait state once memory is ready.
  assign eff_state = (state == ST_WAIT) ? saved_state : state;

  // Next-state and pipeline control decode, highest priority first.
  always_comb begin
    PCWrite   = 1'b1;
    IFIDWrite = 1'b1;
    if_flush  = 1'b0;
    bubble    = 1'b0;
    pipe_en   = 1'b1;
    state_nxt = eff_state;
    saved_nxt = saved_state;
    rem_nxt   = remaining;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (mem_wait) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      pipe_en   = 1'b0;
      state_nxt = ST_WAIT;
      saved_nxt = eff_state;
    end else if (ex_branch_taken) begin
      // ID holds a wrong-path instruction, so any pending load-use stall is dropped.
      if_flush  = 1'b1;
      bubble    = 1'b1;
      state_nxt = ST_RUN;
      rem_nxt   = '0;
      flush_inc = 1'b1;
    end else if ((eff_state == ST_STALL) || lu_hit) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      bubble    = 1'b1;
      stall_inc = 1'b1;
      if (eff_state == ST_STALL) begin
        if (remaining <= REM_W'(1)) begin
          rem_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          rem_nxt = remaining - REM_W'(1);
        end
      end else if (LU_STALL_CYC > 1) begin
        state_nxt = ST_STALL;
        rem_nxt   = REM_W'(LU_STALL_CYC - 1);
      end
    end else if (id_jump) begin
      if_flush  = 1'b1;
      flush_inc = 1'b1;
    end

    // Reset holds the front end closed and the decoder bubbling.
    if (!Reset_L) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
      pipe_en   = 1'b0;
      bubble    = 1'b1;
      if_flush  = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state       <= ST_RUN;
      saved_state <= ST_RUN;
      remaining   <= '0;
    end else begin
      state       <= state_nxt;
      saved_state <= saved_nxt;
      remaining   <= rem_nxt;
    end
  end

  // Consecutive dmem wait cycles; mem_err latches once the limit is reached.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (mem_wait) begin
      if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
        mem_err <= 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (Reset_L),
    .en    (stall_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (Reset_L),
    .en    (flush_inc),
    .clr   (1'b0),
    .count (flush_cnt)
  );

endmodule
